// File: rtl/led_frame_scheduler.sv
// rtl/led_frame_scheduler.sv - double-buffered 2x(8x8) LED frame store and scan scheduler
// Optional PWM dimming is enabled by defining LED_PWM_EN, which adds the brightness port.
module led_frame_scheduler #(
  parameter int DWELL_CYCLES = 16384,
  parameter int BLANK_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
`ifdef LED_PWM_EN
  input  logic [3:0] brightness,
`endif
  output logic       commit_pending,
  output logic       frame_sync,
  output logic [7:0] row,
  output logic [7:0] colx,
  output logic [7:0] coly
);

  localparam int CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    slot_q, slot_d;
  logic          commit_pending_q, commit_pending_d;
  logic          frame_sync_q, frame_sync_d;
  logic [7:0]    row_q, row_d;
  logic [7:0]    colx_q, colx_d;
  logic [7:0]    coly_q, coly_d;
  logic [7:0]    shadow_q [16];
  logic [7:0]    shadow_d [16];
  logic [7:0]    active_q [16];
  logic [7:0]    active_d [16];

  logic          boundary;
  logic          on;
  logic [2:0]    col;

`ifdef LED_PWM_EN
  logic [3:0]    bright_q, bright_d;
  logic [31:0]   on_len;
`endif

  always_comb begin
    cnt_d            = cnt_q;
    slot_d           = slot_q;
    shadow_d         = shadow_q;
    active_d         = active_q;
    commit_pending_d = commit_pending_q;
    boundary         = (slot_q == 4'hf) && (cnt_q == CNT_LAST);

    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      slot_d = slot_q + 4'd1;
    end else begin
      cnt_d  = cnt_q + CW'(1);
    end

    // Registered from the next-state counters so the pulse coincides with the boundary cycle.
    frame_sync_d = (slot_d == 4'hf) && (cnt_d == CNT_LAST);

    if (wr_valid) begin
      shadow_d[wr_addr] = wr_data;
    end

    // The copy uses the registered shadow, so a same-cycle write waits for the next commit.
    if (boundary && commit_pending_q) begin
      active_d         = shadow_q;
      commit_pending_d = 1'b0;
    end else if (commit && !commit_pending_q) begin
      commit_pending_d = 1'b1;
    end
  end

  always_comb begin
    on = (cnt_q >= CNT_BLANK);
`ifdef LED_PWM_EN
    bright_d = (cnt_q == '0) ? brightness : bright_q;
    on_len   = (32'(DWELL_CYCLES - BLANK_CYCLES) * (32'(bright_q) + 32'd1)) >> 4;
    on       = on && (32'(cnt_q) < (32'(BLANK_CYCLES) + on_len));
`endif
    col    = slot_q[3:1];
    row_d  = on ? active_q[{slot_q[0], col}] : 8'h00;
    colx_d = (on && !slot_q[0]) ? (8'h01 << col) : 8'h00;
    coly_d = (on &&  slot_q[0]) ? (8'h01 << col) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q            <= '0;
      slot_q           <= 4'd0;
      commit_pending_q <= 1'b0;
      frame_sync_q     <= 1'b0;
      row_q            <= 8'h00;
      colx_q           <= 8'h00;
      coly_q           <= 8'h00;
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= 8'h00;
        active_q[i] <= 8'h00;
      end
    end else begin
      cnt_q            <= cnt_d;
      slot_q           <= slot_d;
      commit_pending_q <= commit_pending_d;
      frame_sync_q     <= frame_sync_d;
      row_q            <= row_d;
      colx_q           <= colx_d;
      coly_q           <= coly_d;
      shadow_q         <= shadow_d;
      active_q         <= active_d;
    end
  end

`ifdef LED_PWM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      bright_q <= 4'd0;
    end else begin
      bright_q <= bright_d;
    end
  end
`endif

  assign commit_pending = commit_pending_q;
  assign frame_sync     = frame_sync_q;
  assign row            = row_q;
  assign colx           = colx_q;
  assign coly           = coly_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb/tb_led_frame_scheduler.sv - randomized scoreboard bench for led_frame_scheduler
// Reference model derives slot/dwell position arithmetically from elapsed cycles.
module tb_led_frame_scheduler;

  localparam int D = 32;
  localparam int B = 4;
  localparam int F = 16 * D;
  localparam int NCYC = 8 * F;
  localparam int RST_AT = 6 * F + 200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic [3:0] wr_addr = 4'd0;
  logic [7:0] wr_data = 8'h00;
  logic       commit = 1'b0;
`ifdef LED_PWM_EN
  logic [3:0] brightness = 4'd15;
`endif
  logic       commit_pending;
  logic       frame_sync;
  logic [7:0] row;
  logic [7:0] colx;
  logic [7:0] coly;

  led_frame_scheduler #(.DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk(clk),
    .reset(reset),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .commit(commit),
`ifdef LED_PWM_EN
    .brightness(brightness),
`endif
    .commit_pending(commit_pending),
    .frame_sync(frame_sync),
    .row(row),
    .colx(colx),
    .coly(coly)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  int         t;
  logic [7:0] m_shadow [16];
  logic [7:0] m_active [16];
  logic       m_pending;
  logic [3:0] m_bright;
  logic [7:0] e_row, e_colx, e_coly;
  logic       e_sync;

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < 16; i++) begin
      m_shadow[i] = 8'h00;
      m_active[i] = 8'h00;
    end
    m_pending = 1'b0;
    m_bright  = 4'd0;
    e_row     = 8'h00;
    e_colx    = 8'h00;
    e_coly    = 8'h00;
    e_sync    = 1'b0;
  endtask

  task automatic model_step();
    int  c;
    int  s;
    bit  lit;
    if (!reset) begin
      model_reset();
      return;
    end
    c   = t % D;
    s   = (t / D) % 16;
    lit = (c >= B);
`ifdef LED_PWM_EN
    lit = lit && (c < B + (((D - B) * (int'(m_bright) + 1)) >> 4));
    if (c == 0) m_bright = brightness;
`endif
    e_row  = lit ? m_active[(s % 2) * 8 + s / 2] : 8'h00;
    e_colx = (lit && (s % 2 == 0)) ? 8'(1 << (s / 2)) : 8'h00;
    e_coly = (lit && (s % 2 == 1)) ? 8'(1 << (s / 2)) : 8'h00;
    if ((t % F == F - 1) && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end else if (commit && !m_pending) begin
      m_pending = 1'b1;
    end
    if (wr_valid) m_shadow[wr_addr] = wr_data;
    t++;
    e_sync = (t % F == F - 1);
  endtask

  bit seen_on   = 1'b0;
  bit seen_sync = 1'b0;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_row", 32'(row), 32'h0);
    check("reset_colx", 32'(colx), 32'h0);
    check("reset_coly", 32'(coly), 32'h0);
    check("reset_sync", 32'(frame_sync), 32'h0);
    check("reset_pending", 32'(commit_pending), 32'h0);
    reset = 1'b1;

    for (int cyc = 1; cyc <= NCYC; cyc++) begin
      reset    = !(cyc >= RST_AT && cyc < RST_AT + 3);
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_addr  = 4'($urandom_range(0, 15));
      wr_data  = 8'($urandom);
      commit   = (t >= 3 * F) && ($urandom_range(0, 199) == 0);
`ifdef LED_PWM_EN
      brightness = 4'($urandom_range(0, 15));
`endif
      // Directed corners: commit on a boundary, and a pending commit overtaken by a boundary write.
      if (t == 4 * F - 1) commit = 1'b1;
      if (t == 5 * F - 400) commit = 1'b1;
      if (t == 5 * F - 1) begin
        wr_valid = 1'b1;
        wr_addr  = 4'd3;
        wr_data  = 8'hff;
      end

      @(posedge clk);
      model_step();
      @(negedge clk);

      check("row", 32'(row), 32'(e_row));
      check("colx", 32'(colx), 32'(e_colx));
      check("coly", 32'(coly), 32'(e_coly));
      check("frame_sync", 32'(frame_sync), 32'(e_sync));
      check("commit_pending", 32'(commit_pending), 32'(m_pending));
      check("col_exclusive", 32'(colx != 8'h00 && coly != 8'h00), 32'h0);

      if (!seen_on && colx != 8'h00) begin
        seen_on = 1'b1;
        check("first_on_cycle", 32'(cyc), 32'd5);
        check("first_on_colx", 32'(colx), 32'h01);
      end
      if (!seen_sync && frame_sync) begin
        seen_sync = 1'b1;
        check("first_sync_cycle", 32'(cyc), 32'(F - 1));
      end
    end

    check("seen_on", 32'(seen_on), 32'h1);
    check("seen_sync", 32'(seen_sync), 32'h1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
